// File: rtl/pusch_top.sv
// Simplified NR PUSCH transmit chain: payload, CRC-24A, rate match,
// Gold scrambling, QAM mapping and subcarrier placement.
module pusch_top #(
  parameter int WIDTH_IFFT = 26
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reset_fft,
  input  logic                         reset_div,
  input  logic                         enable,
  input  logic                         Data_in,
  input  logic [1:0]                   base_graph,
  input  logic [1:0]                   rv_number,
  input  logic [3:0]                   process_number,
  input  logic [16:0]                  available_coded_bits,
  input  logic [2:0]                   modulation_order,
  input  logic [5:0]                   N_Rapid,
  input  logic [15:0]                  N_Rnti,
  input  logic [9:0]                   N_cell_ID,
  input  logic                         Config,
  input  logic [3:0]                   N_slot_frame,
  input  logic [6:0]                   N_rb,
  input  logic [1:0]                   En_hopping,
  input  logic [3:0]                   N_symbol,
  input  logic [10:0]                  N_sc_start,
  input  logic [3:0]                   Sym_Start_REM,
  input  logic [3:0]                   Sym_End_REM,
  output logic signed [WIDTH_IFFT-1:0] Data_r,
  output logic signed [WIDTH_IFFT-1:0] Data_i,
  output logic                         Data_valid
);

  localparam int W = WIDTH_IFFT;
  localparam logic [23:0] POLY = 24'h864CFB;

  typedef enum logic [2:0] {
    IDLE, COLLECT, CRC, SCR_INIT, MAP, DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0]  div_cnt;
  logic        tick;
  logic [63:0] buf_q;
  logic [23:0] crc_q;
  logic [6:0]  len_q;
  logic [4:0]  crc_cnt;
  logic [10:0] scr_cnt;
  logic [30:0] x1_q, x2_q, x1_nx, x2_nx;

  logic [16:0] e_q;
  logic [2:0]  qm_q;
  logic [6:0]  nrb_q;
  logic [3:0]  nsym_q, ss_q, se_q;
  logic [10:0] scs_q;
  logic [1:0]  rv_q;
  logic [1:0]  bg_q, hop_q;
  logic [3:0]  proc_q, slot_q;

  logic [3:0]  sym_q;
  logic [10:0] sc_q;
  logic [16:0] sent_q;
  logic [5:0]  rd_q, rd_nx, k0;
  logic [5:0]  bits;
  logic [6:0]  p;
  logic [10:0] nsc;
  logic [3:0]  sym_last;
  logic        map_last;
  logic        is_data;
  logic [30:0] c_init;
  logic        unused_rsvd;

  function automatic logic [23:0] crc_step(
    input logic [23:0] c,
    input logic        b
  );
    return {c[22:0], 1'b0} ^ ((b ^ c[23]) ? POLY : 24'h0);
  endfunction

  function automatic logic [30:0] x1_step(input logic [30:0] x);
    return {x[3] ^ x[0], x[30:1]};
  endfunction

  function automatic logic [30:0] x2_step(input logic [30:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
  endfunction

  function automatic logic [2:0] mag(
    input logic [2:0] qm,
    input logic       a,
    input logic       b
  );
    logic [2:0] m;
    m = 3'd1;
    if (qm == 3'd4)      m = a ? 3'd3 : 3'd1;
    else if (qm == 3'd6) m = a ? (b ? 3'd7 : 3'd5) : (b ? 3'd1 : 3'd3);
    return m;
  endfunction

  function automatic logic signed [W-1:0] lvl(
    input logic       s,
    input logic [2:0] m
  );
    logic signed [W-1:0] v;
    v = '0;
    v[W-3:W-5] = m;
    return s ? -v : v;
  endfunction

  assign tick = (div_cnt == 4'hF);
  assign unused_rsvd = ^{bg_q, hop_q, proc_q, slot_q};

  assign c_init = Config ?
    {N_Rnti[14:0], N_Rapid, N_cell_ID} :
    {N_Rnti, 5'b0, N_cell_ID};

  assign k0 = 6'(({7'b0, rv_q} * {2'b0, len_q}) >> 2);
  assign nsc = {1'b0, nrb_q, 3'b0} + {2'b0, nrb_q, 2'b0};
  assign sym_last = (se_q < ss_q) ? ss_q : se_q;
  assign map_last = (sym_q == sym_last) && (sc_q == nsc - 11'd1);

  assign is_data = (sym_q != nsym_q) && (sc_q >= scs_q) &&
    (({1'b0, sent_q} + {15'b0, qm_q}) <= {1'b0, e_q});

  // Qm rate-matched, scrambled bits and the state after consuming them
  always_comb begin
    x1_nx = x1_q;
    x2_nx = x2_q;
    bits  = '0;
    p     = '0;
    for (int j = 0; j < 6; j++) begin
      p = {1'b0, rd_q} + 7'(j);
      if (p >= len_q) p = p - len_q;
      bits[j] = buf_q[p[5:0]] ^ x1_q[j] ^ x2_q[j];
      if (3'(j) < qm_q) begin
        x1_nx = x1_step(x1_nx);
        x2_nx = x2_step(x2_nx);
      end
    end
    p = {1'b0, rd_q} + {4'b0, qm_q};
    if (p >= len_q) p = p - len_q;
    rd_nx = p[5:0];
  end

  assign Data_valid = (state == MAP) && (nsc != 11'd0);

  assign Data_r = (Data_valid && is_data) ?
    lvl(bits[0], mag(qm_q, bits[2], bits[4])) : '0;
  assign Data_i = (Data_valid && is_data) ?
    lvl(bits[1], mag(qm_q, bits[3], bits[5])) : '0;

  always_ff @(posedge clk) begin
    if (reset || !reset_div) div_cnt <= '0;
    else                     div_cnt <= div_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || reset_fft) state <= IDLE;
    else                    state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (tick && enable) state_nx = COLLECT;
      COLLECT:  if (tick && !enable) state_nx = CRC;
      CRC:      if (crc_cnt == 5'd23) state_nx = SCR_INIT;
      SCR_INIT: if (scr_cnt == 11'd1599) state_nx = MAP;
      MAP:      if (nsc == 11'd0 || map_last) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      crc_q   <= '0;
      len_q   <= '0;
      crc_cnt <= '0;
      scr_cnt <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      e_q     <= '0;
      qm_q    <= 3'd2;
      nrb_q   <= '0;
      nsym_q  <= '0;
      ss_q    <= '0;
      se_q    <= '0;
      scs_q   <= '0;
      rv_q    <= '0;
      bg_q    <= '0;
      hop_q   <= '0;
      proc_q  <= '0;
      slot_q  <= '0;
      sym_q   <= '0;
      sc_q    <= '0;
      sent_q  <= '0;
      rd_q    <= '0;
    end else begin
      case (state)
        IDLE: if (tick && enable) begin
          buf_q[0] <= Data_in;
          crc_q    <= crc_step(24'h0, Data_in);
          len_q    <= 7'd1;
          crc_cnt  <= '0;
        end
        COLLECT: if (tick && enable && len_q < 7'd40) begin
          buf_q[len_q[5:0]] <= Data_in;
          crc_q <= crc_step(crc_q, Data_in);
          len_q <= len_q + 7'd1;
        end
        CRC: begin
          buf_q[len_q[5:0]] <= crc_q[23];
          crc_q   <= {crc_q[22:0], 1'b0};
          len_q   <= len_q + 7'd1;
          crc_cnt <= crc_cnt + 5'd1;
          if (crc_cnt == 5'd23) begin
            e_q    <= available_coded_bits;
            qm_q   <= (modulation_order == 3'd4 ||
                       modulation_order == 3'd6) ?
                      modulation_order : 3'd2;
            nrb_q  <= N_rb;
            nsym_q <= N_symbol;
            ss_q   <= Sym_Start_REM;
            se_q   <= Sym_End_REM;
            scs_q  <= N_sc_start;
            rv_q   <= rv_number;
            bg_q   <= base_graph;
            hop_q  <= En_hopping;
            proc_q <= process_number;
            slot_q <= N_slot_frame;
            x1_q   <= 31'd1;
            x2_q   <= c_init;
            scr_cnt <= '0;
          end
        end
        SCR_INIT: begin
          x1_q    <= x1_step(x1_q);
          x2_q    <= x2_step(x2_q);
          scr_cnt <= scr_cnt + 11'd1;
          if (scr_cnt == 11'd1599) begin
            rd_q   <= k0;
            sym_q  <= ss_q;
            sc_q   <= '0;
            sent_q <= '0;
          end
        end
        MAP: if (nsc != 11'd0) begin
          if (is_data) begin
            rd_q   <= rd_nx;
            x1_q   <= x1_nx;
            x2_q   <= x2_nx;
            sent_q <= sent_q + {14'b0, qm_q};
          end
          if (sc_q == nsc - 11'd1) begin
            sc_q  <= '0;
            sym_q <= sym_q + 4'd1;
          end else begin
            sc_q <= sc_q + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pusch_top.sv
// Directed bench for pusch_top: payload vectors checked against a
// reference chain built from the standard definitions.
module tb_pusch_top;

  localparam int W  = 26;
  localparam int SC = 1 << (W - 5);

  logic        clk = 1'b0;
  logic        reset, reset_fft, reset_div, enable, Data_in;
  logic [1:0]  base_graph, rv_number, En_hopping;
  logic [3:0]  process_number, N_slot_frame, N_symbol;
  logic [3:0]  Sym_Start_REM, Sym_End_REM;
  logic [16:0] available_coded_bits;
  logic [2:0]  modulation_order;
  logic [5:0]  N_Rapid;
  logic [15:0] N_Rnti;
  logic [9:0]  N_cell_ID;
  logic        Config;
  logic [6:0]  N_rb;
  logic [10:0] N_sc_start;
  logic signed [W-1:0] Data_r, Data_i;
  logic        Data_valid;

  int n_vec = 0;
  int n_err = 0;
  logic pay [64];
  int   k_in;
  logic [51:0] exp_q[$];
  logic [51:0] got_q[$];

  pusch_top #(.WIDTH_IFFT(W)) dut (
    .clk(clk), .reset(reset), .reset_fft(reset_fft),
    .reset_div(reset_div), .enable(enable), .Data_in(Data_in),
    .base_graph(base_graph), .rv_number(rv_number),
    .process_number(process_number),
    .available_coded_bits(available_coded_bits),
    .modulation_order(modulation_order), .N_Rapid(N_Rapid),
    .N_Rnti(N_Rnti), .N_cell_ID(N_cell_ID), .Config(Config),
    .N_slot_frame(N_slot_frame), .N_rb(N_rb),
    .En_hopping(En_hopping), .N_symbol(N_symbol),
    .N_sc_start(N_sc_start), .Sym_Start_REM(Sym_Start_REM),
    .Sym_End_REM(Sym_End_REM), .Data_r(Data_r), .Data_i(Data_i),
    .Data_valid(Data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pay(input logic [63:0] pat, input int k);
    k_in = k;
    for (int i = 0; i < 64; i++) pay[i] = pat[63-i];
  endtask

  task automatic build_model();
    logic [23:0] rem;
    logic [31:0] ci;
    logic bm [64];
    bit   x1[], x2[];
    logic b [6];
    logic t, bit_in;
    int kk, nn, k0, qm, lend, sent, ptr, len, ii, qq;
    int s [6];
    kk = (k_in > 40) ? 40 : k_in;
    rem = '0;
    for (int i = 0; i < kk + 24; i++) begin
      bit_in = (i < kk) ? pay[i] : 1'b0;
      t = rem[23];
      rem = {rem[22:0], bit_in};
      if (t) rem = rem ^ 24'h864CFB;
    end
    for (int i = 0; i < kk; i++) bm[i] = pay[i];
    for (int j = 0; j < 24; j++) bm[kk+j] = rem[23-j];
    nn = kk + 24;
    k0 = (int'(rv_number) * nn) / 4;
    if (Config)
      ci = ({16'b0, N_Rnti} << 16) + ({26'b0, N_Rapid} << 10) +
           {22'b0, N_cell_ID};
    else
      ci = ({16'b0, N_Rnti} << 15) + {22'b0, N_cell_ID};
    len = 1600 + int'(available_coded_bits) + 8;
    x1 = new[len + 31];
    x2 = new[len + 31];
    for (int n = 0; n < 31; n++) begin
      x1[n] = (n == 0);
      x2[n] = ci[n];
    end
    for (int n = 0; n < len; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    qm = (modulation_order == 4 || modulation_order == 6) ?
         int'(modulation_order) : 2;
    lend = (Sym_End_REM < Sym_Start_REM) ? int'(Sym_Start_REM) :
           int'(Sym_End_REM);
    sent = 0;
    ptr = k0;
    exp_q.delete();
    for (int l = int'(Sym_Start_REM); l <= lend; l++) begin
      for (int k = 0; k < 12 * int'(N_rb); k++) begin
        ii = 0;
        qq = 0;
        if (l != int'(N_symbol) && k >= int'(N_sc_start) &&
            sent + qm <= int'(available_coded_bits)) begin
          for (int j = 0; j < 6; j++) b[j] = 1'b0;
          for (int j = 0; j < qm; j++) begin
            b[j] = bm[ptr] ^ x1[sent+j+1600] ^ x2[sent+j+1600];
            ptr = (ptr + 1) % nn;
          end
          sent += qm;
          for (int j = 0; j < 6; j++) s[j] = 1 - 2 * int'(b[j]);
          if (qm == 2) begin
            ii = s[0];
            qq = s[1];
          end else if (qm == 4) begin
            ii = s[0] * (2 - s[2]);
            qq = s[1] * (2 - s[3]);
          end else begin
            ii = s[0] * (4 - s[2] * (2 - s[4]));
            qq = s[1] * (4 - s[3] * (2 - s[5]));
          end
        end
        exp_q.push_back({26'(ii * SC), 26'(qq * SC)});
      end
    end
  endtask

  task automatic send_pay(input bit noise);
    for (int i = 0; i < k_in; i++) begin
      enable = 1'b1;
      Data_in = pay[i];
      repeat (16) step();
    end
    enable = 1'b0;
    Data_in = 1'b0;
    repeat (16) step();
    if (noise) begin
      for (int i = 0; i < 100; i++) begin
        enable = 1'b1;
        Data_in = 1'($urandom_range(0, 1));
        step();
      end
      enable = 1'b0;
    end
  endtask

  task automatic run_pkt(input string tag, input bit noise);
    int waited;
    build_model();
    send_pay(noise);
    got_q.delete();
    waited = 0;
    while (!Data_valid && waited < 3000) begin
      step();
      waited++;
    end
    while (Data_valid && got_q.size() < 20000) begin
      got_q.push_back({Data_r, Data_i});
      step();
    end
    chk({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    chk({tag, " done"}, {Data_valid, Data_r, Data_i}, 64'd0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s s%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int seen;
    reset = 1'b1; reset_fft = 1'b0; reset_div = 1'b0;
    enable = 1'b0; Data_in = 1'b0;
    base_graph = 2'd1; rv_number = 2'd0; process_number = 4'd3;
    available_coded_bits = 17'd8; modulation_order = 3'd2;
    N_Rapid = 6'd0; N_Rnti = 16'd100; N_cell_ID = 10'd1;
    Config = 1'b0; N_slot_frame = 4'd2; N_rb = 7'd1;
    En_hopping = 2'd0; N_symbol = 4'd0; N_sc_start = 11'd10;
    Sym_Start_REM = 4'd1; Sym_End_REM = 4'd1;
    set_pay(64'h8000_0000_0000_0000, 1);

    repeat (3) step();
    chk("rst valid", 64'(Data_valid), 64'd0);
    chk("rst r", 64'(Data_r), 64'd0);
    chk("rst i", 64'(Data_i), 64'd0);

    reset = 1'b0;
    enable = 1'b1;
    Data_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 2200; i++) begin
      if (i == 64) enable = 1'b0;
      step();
      if (Data_valid) seen++;
    end
    chk("nodiv", 64'(seen), 64'd0);
    reset_div = 1'b1;
    repeat (5) step();

    run_pkt("one_bit", 1'b0);

    set_pay(64'hB38D_0000_0000_0000, 16);
    N_Rnti = 16'd31578; N_cell_ID = 10'd820; Config = 1'b0;
    modulation_order = 3'd4; available_coded_bits = 17'd120;
    N_rb = 7'd2; N_sc_start = 11'd3; N_symbol = 4'd3;
    Sym_Start_REM = 4'd2; Sym_End_REM = 4'd4;
    run_pkt("qam16", 1'b1);

    set_pay(64'hA5C3_9E17_D24B_6F08, 12);
    N_Rnti = 16'hBEEF; N_cell_ID = 10'd1007; N_Rapid = 6'd37;
    Config = 1'b1; modulation_order = 3'd2;
    available_coded_bits = 17'd400; N_rb = 7'd100;
    N_sc_start = 11'd5; N_symbol = 4'd3;
    Sym_Start_REM = 4'd1; Sym_End_REM = 4'd3;
    run_pkt("wide", 1'b0);

    set_pay(64'hCA00_0000_0000_0000, 8);
    rv_number = 2'd2; Config = 1'b0; N_Rnti = 16'd7;
    N_cell_ID = 10'd500; modulation_order = 3'd6;
    available_coded_bits = 17'd60; N_rb = 7'd1;
    N_sc_start = 11'd0; N_symbol = 4'd5;
    Sym_Start_REM = 4'd0; Sym_End_REM = 4'd1;
    run_pkt("rv2", 1'b0);

    set_pay(64'h1234_5678_9ABC_DEF0, 45);
    rv_number = 2'd3; modulation_order = 3'd7;
    available_coded_bits = 17'd200; N_rb = 7'd3;
    Sym_Start_REM = 4'd5; Sym_End_REM = 4'd2; N_symbol = 4'd9;
    run_pkt("cap_rv3", 1'b0);

    set_pay(64'hE000_0000_0000_0000, 3);
    rv_number = 2'd1; available_coded_bits = 17'd0; N_rb = 7'd1;
    Sym_Start_REM = 4'd0; Sym_End_REM = 4'd0;
    run_pkt("e_zero", 1'b0);

    set_pay(64'h4000_0000_0000_0000, 2);
    available_coded_bits = 17'd40; N_rb = 7'd0;
    run_pkt("nrb_zero", 1'b0);

    set_pay(64'hF0F0_0000_0000_0000, 10);
    rv_number = 2'd0; modulation_order = 3'd2; N_rb = 7'd2;
    available_coded_bits = 17'd30; N_sc_start = 11'd0;
    send_pay(1'b0);
    seen = 0;
    while (!Data_valid && seen < 3000) begin
      step();
      seen++;
    end
    repeat (5) step();
    chk("fft pre", 64'(Data_valid), 64'd1);
    reset_fft = 1'b1;
    step();
    reset_fft = 1'b0;
    chk("fft abort", {Data_valid, Data_r, Data_i}, 64'd0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (Data_valid) seen++;
    end
    chk("fft quiet", 64'(seen), 64'd0);

    set_pay(64'h6DB6_D000_0000_0000, 20);
    rv_number = 2'd1; modulation_order = 3'd6;
    available_coded_bits = 17'd90; N_rb = 7'd2;
    N_sc_start = 11'd4; N_symbol = 4'd7;
    Sym_Start_REM = 4'd6; Sym_End_REM = 4'd8;
    run_pkt("after_fft", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
